// File: rtl/comparador.sv
// comparador: four-input maximum detector for 7-bit unsigned counts.
// Every cycle it flags each channel whose count equals the largest of the
// four. Ties flag all tied channels, and an all-zero field flags none.
// Flags and the maximum are registered, giving exactly one cycle of latency.
// Optional feature macro: COMPARADOR_TIE_EN adds the registered Tie output,
// which is high when two or more flags are set.

module comparador (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] BusA,
   input  logic [6:0] BusB,
   input  logic [6:0] BusC,
   input  logic [6:0] BusD,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
`ifdef COMPARADOR_TIE_EN
   output logic       Tie,
`endif
   output logic [6:0] Max
);

   // Combinational compare tree.
   logic [6:0] w_max_ab;
   logic [6:0] w_max_cd;
   logic [6:0] w_max;
   logic       w_nonzero;
   logic       w_flag_a;
   logic       w_flag_b;
   logic       w_flag_c;
   logic       w_flag_d;

   // Registered results.
   logic       r_a;
   logic       r_b;
   logic       r_c;
   logic       r_d;
   logic [6:0] r_max;

   // Two-level maximum tree: pairwise maxima first, then the final maximum.
   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned, which would infer a latch.
      w_max_ab = BusA;
      w_max_cd = BusC;
      if (BusB > BusA) w_max_ab = BusB;
      if (BusD > BusC) w_max_cd = BusD;
      w_max = w_max_ab;
      if (w_max_cd > w_max_ab) w_max = w_max_cd;
   end

   // A channel wins when it equals the maximum, unless the maximum is zero.
   assign w_nonzero = (w_max != 7'd0);
   assign w_flag_a  = (BusA == w_max) && w_nonzero;
   assign w_flag_b  = (BusB == w_max) && w_nonzero;
   assign w_flag_c  = (BusC == w_max) && w_nonzero;
   assign w_flag_d  = (BusD == w_max) && w_nonzero;

   // Output register; synchronous reset has priority over the input data.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its inputs from before the edge, independent of statement order.
      if (rst) begin
         r_a   <= 1'b0;
         r_b   <= 1'b0;
         r_c   <= 1'b0;
         r_d   <= 1'b0;
         r_max <= 7'd0;
      end else begin
         r_a   <= w_flag_a;
         r_b   <= w_flag_b;
         r_c   <= w_flag_c;
         r_d   <= w_flag_d;
         r_max <= w_max;
      end
   end

   assign A   = r_a;
   assign B   = r_b;
   assign C   = r_c;
   assign D   = r_d;
   assign Max = r_max;

`ifdef COMPARADOR_TIE_EN
   logic w_tie;
   logic r_tie;

   // Two or more flags set: true exactly when some pair of flags is set.
   assign w_tie = (w_flag_a & w_flag_b) | (w_flag_a & w_flag_c) |
                  (w_flag_a & w_flag_d) | (w_flag_b & w_flag_c) |
                  (w_flag_b & w_flag_d) | (w_flag_c & w_flag_d);

   // Tie register, aligned with the flag registers and cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) r_tie <= 1'b0;
      else     r_tie <= w_tie;
   end

   assign Tie = r_tie;
`endif

endmodule

// File: tb/tb_comparador.sv
// tb_comparador: directed testbench for comparador. Each step drives a vector,
// confirms the outputs still hold the previous result before the edge, then
// confirms the new result just after the edge. Tie is checked when the
// COMPARADOR_TIE_EN macro is defined.

module tb_comparador;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] BusA, BusB, BusC, BusD;
   logic       A, B, C, D;
   logic [6:0] Max;
`ifdef COMPARADOR_TIE_EN
   logic       Tie;
`endif

   int checks = 0;
   int errors = 0;

   logic [3:0] prev_flags;
   logic [6:0] prev_max;
   logic       prev_tie;
   logic       have_prev = 1'b0;

   comparador dut (
      .clk  (clk),
      .rst  (rst),
      .BusA (BusA),
      .BusB (BusB),
      .BusC (BusC),
      .BusD (BusD),
      .A    (A),
      .B    (B),
      .C    (C),
      .D    (D),
`ifdef COMPARADOR_TIE_EN
      .Tie  (Tie),
`endif
      .Max  (Max)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] observed,
                      input logic [6:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] exp_flags,
                                input logic [6:0] exp_max, input logic exp_tie);
      chk({tag, " flags"}, {3'b000, A, B, C, D}, {3'b000, exp_flags});
      chk({tag, " max"}, Max, exp_max);
`ifdef COMPARADOR_TIE_EN
      chk({tag, " tie"}, {6'd0, Tie}, {6'd0, exp_tie});
`else
      if (exp_tie === 1'bx) $display("unexpected tie value in %s", tag);
`endif
   endtask

   // One directed step: drive, check held result, clock, check new result.
   task automatic step(input string tag, input logic rst_v,
                       input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d,
                       input logic [3:0] exp_flags, input logic [6:0] exp_max,
                       input logic exp_tie);
      rst  = rst_v;
      BusA = a;
      BusB = b;
      BusC = c;
      BusD = d;
      #1;
      if (have_prev) check_outputs({tag, " held"}, prev_flags, prev_max, prev_tie);
      @(posedge clk);
      #1;
      check_outputs(tag, exp_flags, exp_max, exp_tie);
      prev_flags = exp_flags;
      prev_max   = exp_max;
      prev_tie   = exp_tie;
      have_prev  = 1'b1;
   endtask

   initial begin
      rst  = 1'b1;
      BusA = 7'd0;
      BusB = 7'd0;
      BusC = 7'd0;
      BusD = 7'd0;
      @(negedge clk);

      // Reset for two cycles with arbitrary data, then all zeros.
      step("rst0",      1'b1, 7'd100, 7'd3,   7'd7,   7'd9,   4'b0000, 7'd0,   1'b0);
      step("rst1",      1'b1, 7'd100, 7'd3,   7'd7,   7'd9,   4'b0000, 7'd0,   1'b0);
      step("zeros",     1'b0, 7'd0,   7'd0,   7'd0,   7'd0,   4'b0000, 7'd0,   1'b0);

      // Single winners.
      step("solo_a",    1'b0, 7'd100, 7'd0,   7'd0,   7'd0,   4'b1000, 7'd100, 1'b0);
      step("solo_b",    1'b0, 7'd0,   7'd100, 7'd0,   7'd0,   4'b0100, 7'd100, 1'b0);
      step("solo_c",    1'b0, 7'd0,   7'd0,   7'd100, 7'd0,   4'b0010, 7'd100, 1'b0);
      step("solo_d",    1'b0, 7'd0,   7'd0,   7'd0,   7'd100, 4'b0001, 7'd100, 1'b0);

      // Ties.
      step("tie_ab",    1'b0, 7'd100, 7'd100, 7'd0,   7'd0,   4'b1100, 7'd100, 1'b1);
      step("tie_abc",   1'b0, 7'd100, 7'd100, 7'd100, 7'd25,  4'b1110, 7'd100, 1'b1);
      step("tie_cd",    1'b0, 7'd0,   7'd2,   7'd100, 7'd100, 4'b0011, 7'd100, 1'b1);
      step("tie_bc",    1'b0, 7'd0,   7'd100, 7'd100, 7'd4,   4'b0110, 7'd100, 1'b1);
      step("tie_all",   1'b0, 7'd5,   7'd5,   7'd5,   7'd5,   4'b1111, 7'd5,   1'b1);

      // Mixed values.
      step("mix1",      1'b0, 7'd100, 7'd100, 7'd50,  7'd50,  4'b1100, 7'd100, 1'b1);
      step("mix2",      1'b0, 7'd50,  7'd50,  7'd100, 7'd100, 4'b0011, 7'd100, 1'b1);
      step("mix3",      1'b0, 7'd25,  7'd50,  7'd50,  7'd0,   4'b0110, 7'd50,  1'b1);
      step("mix4",      1'b0, 7'd25,  7'd50,  7'd50,  7'd25,  4'b0110, 7'd50,  1'b1);
      step("mix5",      1'b0, 7'd126, 7'd127, 7'd0,   7'd0,   4'b0100, 7'd127, 1'b0);

      // Boundaries.
      step("top_ad",    1'b0, 7'd127, 7'd126, 7'd0,   7'd127, 4'b1001, 7'd127, 1'b1);
      step("one_a",     1'b0, 7'd1,   7'd0,   7'd0,   7'd0,   4'b1000, 7'd1,   1'b0);
      step("top_d",     1'b0, 7'd0,   7'd0,   7'd0,   7'd127, 4'b0001, 7'd127, 1'b0);

      // Reset mid-stream discards the in-flight data, then operation resumes.
      step("mid_rst",   1'b1, 7'd9,   7'd8,   7'd7,   7'd6,   4'b0000, 7'd0,   1'b0);
      step("resume1",   1'b0, 7'd9,   7'd8,   7'd7,   7'd6,   4'b1000, 7'd9,   1'b0);
      step("resume2",   1'b0, 7'd3,   7'd60,  7'd60,  7'd60,  4'b0111, 7'd60,  1'b1);
      step("resume3",   1'b0, 7'd0,   7'd0,   7'd0,   7'd0,   4'b0000, 7'd0,   1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
